// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the four-zone alarm controller.
//   - alarm_state_e : state encoding presented on state_o
//   - ST_*          : the same encodings as plain logic constants for the FSM
//   - ZONES         : number of zone sensor inputs
//   - ENTRY_ZONE    : index of the entry-door zone (delayed alarm)
package alarm_pkg;

    localparam int ZONES      = 4;
    localparam int ENTRY_ZONE = 0;

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } alarm_state_e;

    localparam logic [2:0] ST_DISARMED = 3'd0;
    localparam logic [2:0] ST_EXIT     = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_ENTRY    = 3'd3;
    localparam logic [2:0] ST_ALARM    = 3'd4;

endpackage

// File: rtl/alarm_sync2.sv
// alarm_sync2: two-flop synchroniser for asynchronous sensor inputs.
// Ports:
//   clk - sampling clock
//   rst - asynchronous reset, active-high (clears both stages)
//   d   - raw asynchronous input vector
//   q   - synchronised output, two cycles behind d
module alarm_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: arm/disarm sequencer for a four-zone alarm.
// Synchronises the zone sensors, applies per-zone bypass masking and runs the
// DISARMED -> EXIT -> ARMED -> ENTRY -> ALARM state machine with a shared
// down-counter for the exit delay, entry grace and siren duration.
// Optional build macro: ALARM_TAMPER_EN adds tamper_in / tamper_latched.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   arm_req         - arm request (honoured only in DISARMED)
//   disarm_req      - disarm request (beats every other event)
//   zone_in[3:0]    - raw sensors; bit0 entry door, bits 1-3 instant zones
//   zone_mask[3:0]  - 1 = zone bypassed
//   siren           - sounder drive, high in ALARM
//   armed           - high in ARMED, ENTRY and ALARM
//   state_o[2:0]    - current state encoding
//   zone_latched    - sticky record of zones that caused an alarm
//   tamper_in       - (ALARM_TAMPER_EN) raw unmaskable tamper loop
//   tamper_latched  - (ALARM_TAMPER_EN) sticky tamper record
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int EXIT_CYCLES  = 16,
    parameter int ENTRY_CYCLES = 16,
    parameter int SIREN_CYCLES = 64,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_req,
    input  logic             disarm_req,
    input  logic [ZONES-1:0] zone_in,
    input  logic [ZONES-1:0] zone_mask,
`ifdef ALARM_TAMPER_EN
    input  logic             tamper_in,
    output logic             tamper_latched,
`endif
    output logic             siren,
    output logic             armed,
    output logic [2:0]       state_o,
    output logic [ZONES-1:0] zone_latched
);

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);
    localparam logic [ZONES-1:0] ENTRY_BIT  = ZONES'(1) << ENTRY_ZONE;

`ifdef ALARM_TAMPER_EN
    localparam int SW = ZONES + 1;
    logic [SW-1:0] raw_in;
    assign raw_in = {tamper_in, zone_in};
`else
    localparam int SW = ZONES;
    logic [SW-1:0] raw_in;
    assign raw_in = zone_in;
`endif

    logic [SW-1:0]    sync_q;
    logic [ZONES-1:0] trip;
    logic             instant_trip;
    logic             entry_trip;

    alarm_sync2 #(
        .WIDTH (SW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (sync_q)
    );

    assign trip         = sync_q[ZONES-1:0] & ~zone_mask;
    assign instant_trip = |(trip & ~ENTRY_BIT);
    assign entry_trip   = |(trip & ENTRY_BIT);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ZONES-1:0] latched_q, latched_d;
    logic             siren_q, armed_q;
    logic             tl_q, tl_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        latched_d = latched_q;
        tl_d      = tl_q;

        case (state_q)
            ST_DISARMED: begin
                if (arm_req && !disarm_req) begin
                    state_d   = ST_EXIT;
                    cnt_d     = EXIT_LOAD;
                    latched_d = '0;
                    tl_d      = 1'b0;
                end
            end
            ST_EXIT: begin
                if (disarm_req) begin
                    state_d = ST_DISARMED;
                end else if (cnt_zero) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (disarm_req) begin
                    state_d = ST_DISARMED;
                end else if (instant_trip) begin
                    state_d   = ST_ALARM;
                    cnt_d     = SIREN_LOAD;
                    latched_d = latched_q | trip;
                end else if (entry_trip) begin
                    state_d = ST_ENTRY;
                    cnt_d   = ENTRY_LOAD;
                end
            end
            ST_ENTRY: begin
                if (disarm_req) begin
                    state_d = ST_DISARMED;
                end else if (instant_trip) begin
                    state_d   = ST_ALARM;
                    cnt_d     = SIREN_LOAD;
                    latched_d = latched_q | trip;
                end else if (cnt_zero) begin
                    // Grace expired: blame the entry door.
                    state_d   = ST_ALARM;
                    cnt_d     = SIREN_LOAD;
                    latched_d = latched_q | ENTRY_BIT;
                end
            end
            ST_ALARM: begin
                if (disarm_req) begin
                    state_d = ST_DISARMED;
                end else begin
                    latched_d = latched_q | trip;
                    if (cnt_zero) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            default: begin
                state_d = ST_DISARMED;
            end
        endcase

`ifdef ALARM_TAMPER_EN
        // Tamper overrides everything except disarm; an arm request in the
        // same cycle must not clear the zone record.
        if (!disarm_req && sync_q[ZONES]) begin
            tl_d = 1'b1;
            if (state_q != ST_ALARM) begin
                state_d = ST_ALARM;
                cnt_d   = SIREN_LOAD;
                if (state_q == ST_DISARMED) begin
                    latched_d = latched_q;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_DISARMED;
            cnt_q     <= '0;
            latched_q <= '0;
            tl_q      <= 1'b0;
            siren_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            latched_q <= latched_d;
            tl_q      <= tl_d;
            siren_q   <= (state_d == ST_ALARM);
            armed_q   <= (state_d == ST_ARMED) || (state_d == ST_ENTRY) ||
                         (state_d == ST_ALARM);
        end
    end

    assign siren        = siren_q;
    assign armed        = armed_q;
    assign state_o      = state_q;
    assign zone_latched = latched_q;

`ifdef ALARM_TAMPER_EN
    assign tamper_latched = tl_q;
`else
    // Tamper record only exists in the tamper build.
    logic unused_tl;
    assign unused_tl = tl_q ^ tl_d;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: scoreboard bench for alarm_controller with
// EXIT_CYCLES = 4, ENTRY_CYCLES = 4, SIREN_CYCLES = 8.
// Stimulus pushes hand-computed expectations tagged with the cycle at which
// they must hold; a monitor on the falling edge pops and compares them.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm_req;
    logic       disarm_req;
    logic [3:0] zone_in;
    logic [3:0] zone_mask;
    logic       siren;
    logic       armed;
    logic [2:0] state_o;
    logic [3:0] zone_latched;
    logic       tamper_in;
    logic       tamper_latched;

    alarm_controller #(
        .EXIT_CYCLES  (4),
        .ENTRY_CYCLES (4),
        .SIREN_CYCLES (8),
        .CNT_W        (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm_req        (arm_req),
        .disarm_req     (disarm_req),
        .zone_in        (zone_in),
        .zone_mask      (zone_mask),
`ifdef ALARM_TAMPER_EN
        .tamper_in      (tamper_in),
        .tamper_latched (tamper_latched),
`endif
        .siren          (siren),
        .armed          (armed),
        .state_o        (state_o),
        .zone_latched   (zone_latched)
    );

`ifndef ALARM_TAMPER_EN
    assign tamper_latched = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [2:0] st;
        logic       sir;
        logic       arm;
        logic [3:0] zl;
        logic       tl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic compare(input string nm, input logic [2:0] st, input logic sir,
                           input logic arm, input logic [3:0] zl, input logic tl);
        logic ok;
        ok = (state_o === st) && (siren === sir) && (armed === arm) && (zone_latched === zl);
`ifdef ALARM_TAMPER_EN
        ok = ok && (tamper_latched === tl);
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s @cyc %0d: got st=%0d siren=%b armed=%b zl=%b tl=%b, want st=%0d siren=%b armed=%b zl=%b tl=%b",
                     nm, cyc, state_o, siren, armed, zone_latched, tamper_latched,
                     st, sir, arm, zl, tl);
        end
    endtask

    task automatic exp_at(input int c, input string nm, input logic [2:0] st, input logic sir,
                          input logic arm, input logic [3:0] zl, input logic tl);
        exp_t e;
        e.cyc = c; e.name = nm; e.st = st; e.sir = sir; e.arm = arm; e.zl = zl; e.tl = tl;
        sb.push_back(e);
    endtask

    // Monitor: checks every expectation due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                compare(sb[i].name, sb[i].st, sb[i].sir, sb[i].arm, sb[i].zl, sb[i].tl);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed: due cyc %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic nxt(input int n);
        repeat (n) @(negedge clk);
    endtask

    int c, t, u, v, w, x, y, z;

    initial begin
        rst = 1'b1; arm_req = 1'b0; disarm_req = 1'b0;
        zone_in = 4'b0000; zone_mask = 4'b0000; tamper_in = 1'b0;
        #12;
        compare("reset", 3'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        nxt(1);

        // Arm with exit delay; zone 1 active during EXIT is ignored.
        c = cyc;
        arm_req = 1'b1; zone_in = 4'b0010;
        exp_at(c + 1, "exit_entered",     3'd1, 1'b0, 1'b0, 4'b0000, 1'b0);
        exp_at(c + 3, "exit_ignores_zone", 3'd1, 1'b0, 1'b0, 4'b0000, 1'b0);
        exp_at(c + 4, "exit_last_cycle",  3'd1, 1'b0, 1'b0, 4'b0000, 1'b0);
        exp_at(c + 5, "armed_after_exit", 3'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        exp_at(c + 6, "armed_hold",       3'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        nxt(1); arm_req = 1'b0;
        nxt(2); zone_in = 4'b0000;
        nxt(3);

        // Instant zone 2 alarm, siren auto-silences after 8 cycles.
        t = cyc;
        zone_in = 4'b0100;
        exp_at(t + 2,  "instant_sync_delay", 3'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        exp_at(t + 3,  "instant_alarm",      3'd4, 1'b1, 1'b1, 4'b0100, 1'b0);
        exp_at(t + 10, "siren_last_cycle",   3'd4, 1'b1, 1'b1, 4'b0100, 1'b0);
        exp_at(t + 11, "siren_silenced",     3'd2, 1'b0, 1'b1, 4'b0100, 1'b0);
        nxt(1); zone_in = 4'b0000;
        nxt(11);

        // Entry door trips, disarmed during grace.
        u = cyc;
        zone_in = 4'b0001;
        exp_at(u + 2, "entry_sync_delay", 3'd2, 1'b0, 1'b1, 4'b0100, 1'b0);
        exp_at(u + 3, "entry_grace",      3'd3, 1'b0, 1'b1, 4'b0100, 1'b0);
        exp_at(u + 4, "entry_grace_hold", 3'd3, 1'b0, 1'b1, 4'b0100, 1'b0);
        exp_at(u + 5, "entry_disarmed",   3'd0, 1'b0, 1'b0, 4'b0100, 1'b0);
        exp_at(u + 6, "disarmed_hold",    3'd0, 1'b0, 1'b0, 4'b0100, 1'b0);
        nxt(1); zone_in = 4'b0000;
        nxt(3); disarm_req = 1'b1;
        nxt(1); disarm_req = 1'b0;
        nxt(1);

        // Re-arm clears the record; entry grace expires into ALARM.
        v = cyc;
        arm_req = 1'b1;
        exp_at(v + 1, "rearm_clears_latch", 3'd1, 1'b0, 1'b0, 4'b0000, 1'b0);
        exp_at(v + 5, "rearmed",            3'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        nxt(1); arm_req = 1'b0;
        nxt(5);
        w = cyc;
        zone_in = 4'b0001;
        exp_at(w + 3,  "entry2_grace",       3'd3, 1'b0, 1'b1, 4'b0000, 1'b0);
        exp_at(w + 6,  "entry2_last_grace",  3'd3, 1'b0, 1'b1, 4'b0000, 1'b0);
        exp_at(w + 7,  "entry_expiry_alarm", 3'd4, 1'b1, 1'b1, 4'b0001, 1'b0);
        exp_at(w + 14, "alarm_at_expiry",    3'd4, 1'b1, 1'b1, 4'b0001, 1'b0);
        exp_at(w + 15, "disarm_beats_expiry", 3'd0, 1'b0, 1'b0, 4'b0001, 1'b0);
        nxt(1); zone_in = 4'b0000;
        nxt(13); disarm_req = 1'b1;
        nxt(1); disarm_req = 1'b0;

        // arm and disarm together in DISARMED: no transition, record kept.
        nxt(1);
        arm_req = 1'b1; disarm_req = 1'b1;
        exp_at(cyc + 1, "arm_disarm_same", 3'd0, 1'b0, 1'b0, 4'b0001, 1'b0);
        exp_at(cyc + 2, "arm_disarm_hold", 3'd0, 1'b0, 1'b0, 4'b0001, 1'b0);
        nxt(1); arm_req = 1'b0; disarm_req = 1'b0;
        nxt(1);

        // Masked zone 3 active while ARMED; arm_req in ARMED ignored.
        x = cyc;
        arm_req = 1'b1;
        exp_at(x + 1, "arm3_exit",  3'd1, 1'b0, 1'b0, 4'b0000, 1'b0);
        exp_at(x + 5, "arm3_armed", 3'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        nxt(1); arm_req = 1'b0;
        nxt(4); zone_mask = 4'b1000; zone_in = 4'b1000;
        exp_at(x + 8,  "masked_zone_ignored", 3'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        exp_at(x + 11, "masked_zone_hold",    3'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        nxt(4); zone_in = 4'b0000;
        nxt(3); zone_mask = 4'b0000; arm_req = 1'b1;
        exp_at(x + 13, "arm_ignored_armed", 3'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        exp_at(x + 14, "unmask_idle",       3'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        nxt(1); arm_req = 1'b0;
        nxt(1);

        // Asynchronous reset in the middle of an ALARM cycle.
        y = cyc;
        zone_in = 4'b0010;
        exp_at(y + 3, "pre_reset_alarm", 3'd4, 1'b1, 1'b1, 4'b0010, 1'b0);
        nxt(1); zone_in = 4'b0000;
        nxt(3);
        #2 rst = 1'b1;
        #1 compare("async_reset", 3'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        nxt(1); rst = 1'b0;
        nxt(1);

`ifdef ALARM_TAMPER_EN
        // Tamper forces ALARM from DISARMED; disarm beats tamper.
        z = cyc;
        tamper_in = 1'b1;
        exp_at(z + 2,  "tamper_sync_delay", 3'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        exp_at(z + 3,  "tamper_alarm",      3'd4, 1'b1, 1'b1, 4'b0000, 1'b1);
        exp_at(z + 11, "tamper_silenced",   3'd2, 1'b0, 1'b1, 4'b0000, 1'b1);
        nxt(1); tamper_in = 1'b0;
        nxt(11); tamper_in = 1'b1;
        nxt(1); tamper_in = 1'b0;
        nxt(1); disarm_req = 1'b1;
        exp_at(z + 15, "disarm_beats_tamper", 3'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
        exp_at(z + 16, "tamper_disarm_hold",  3'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
        nxt(1); disarm_req = 1'b0;
        nxt(2);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb.size() != 0; i++) nxt(1);
        while (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s pending: due cyc %0d never checked", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
Sequencing controller for the four-zone alarm sensor path.
- Synchronises the four raw zone inputs and applies per-zone masking.
- Runs an arm/disarm state machine with exit delay, entry delay and a timed siren.
- Sits between the top-level pins (ui_in zone and button bits) and uo_out.
- Replaces the purely combinational OR-alarm with a stateful system.

Parameters:
- EXIT_CYCLES, 16: cycles spent in EXIT after arming (at least 1).
- ENTRY_CYCLES, 16: grace cycles after zone 0 (entry door) trips (at least 1).
- SIREN_CYCLES, 64: cycles the siren sounds before auto-silence (at least 1).
- CNT_W, 8: delay counter width. Must satisfy 2^CNT_W >= max(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- arm_req  input  1  arm request, level sampled each cycle, synchronous
- disarm_req  input  1  disarm request, synchronous
- zone_in  input  4  raw asynchronous zone sensors; bit0 = entry zone, bits 1-3 = instant zones
- zone_mask  input  4  1 = zone bypassed, synchronous
- siren  output  1  alarm sounder drive
- armed  output  1  high in ARMED, ENTRY and ALARM
- state_o  output  3  current state encoding
- zone_latched  output  4  sticky record of zones that caused an alarm

Behaviour:
Reset:
- Asynchronous on rst high; all flops clear.
- State = DISARMED; siren = 0, armed = 0, state_o = 0, zone_latched = 0, counter = 0, synchroniser = 0.

Zone path:
- Two-flop synchroniser per zone bit.
- Qualified vector: trip = zsync & ~zone_mask, using the current cycle's zone_mask.
- An edge on zone_in is visible in trip 2 cycles later.

Counter:
- Loaded with N-1 on entry to a timed state; decrements each cycle.
- Exit condition is counter == 0, so each timed state lasts exactly N cycles.

States (state_o encoding):
- DISARMED (0)
  - arm_req -> EXIT, load EXIT_CYCLES-1.
  - Trips are ignored.
- EXIT (1)
  - Trips ignored.
  - Counter reaches 0 -> ARMED.
  - disarm_req -> DISARMED.
- ARMED (2)
  - Any trip[3:1] -> ALARM, load SIREN_CYCLES-1, zone_latched |= trip.
  - Only trip[0] -> ENTRY, load ENTRY_CYCLES-1.
  - Both present -> ALARM.
  - disarm_req -> DISARMED.
- ENTRY (3)
  - disarm_req -> DISARMED.
  - Any trip[3:1] -> ALARM immediately.
  - Counter reaches 0 -> ALARM, zone_latched |= 4'b0001.
- ALARM (4)
  - siren = 1.
  - zone_latched accumulates any further trips.
  - Counter reaches 0 -> ARMED (siren silences). Sensors are re-evaluated the next cycle, so a still-active zone re-alarms.
  - disarm_req -> DISARMED.

Precedence and boundary conditions:
- disarm_req beats every other event in the same cycle, including counter expiry and trips.
- arm_req outside DISARMED is ignored.
- arm_req and disarm_req together in DISARMED: stays DISARMED.
- zone_latched clears only on rst or on the cycle of the DISARMED -> EXIT transition. It persists after disarm for inspection.
- Masking a zone mid-ALARM does not stop the siren.
- Outputs (siren, armed, state_o) are registered from the state: they change 1 cycle after the transition decision.
- Unused state encodings 5-7 -> DISARMED next cycle.

Optional Feature:
Macro ALARM_TAMPER_EN.
- Defined:
  - Adds port tamper_in (input, 1 bit, raw asynchronous), synchronised with the same two flops.
  - tamper_in is not maskable and forces ALARM from any state, including DISARMED and EXIT.
  - Sets zone_latched bit... none; instead sets an extra output tamper_latched (1 bit, sticky, cleared like zone_latched).
  - disarm_req still wins over tamper_in in the same cycle.
- Undefined: neither port exists; behaviour is exactly as above.

Decomposition:
- Package alarm_pkg:
  - state enum typedef with values DISARMED = 0, EXIT = 1, ARMED = 2, ENTRY = 3, ALARM = 4.
  - ZONES = 4.
  - ENTRY_ZONE = 0.
- One natural sub-module, alarm_sync2: parameterised-width two-flop synchroniser with async active-high reset.
- The FSM and counter stay in alarm_controller.

Test Plan:
Bench parameters for all scenarios: EXIT_CYCLES = 4, ENTRY_CYCLES = 4, SIREN_CYCLES = 8.
1. Arm and exit delay: arm_req pulse at cycle 0 -> state_o = 1 at cycle 1, state_o = 2 at cycle 5. zone_in = 4'b0010 held during EXIT -> no alarm.
2. Instant zone: ARMED, zone_in = 4'b0100 at cycle t -> state_o = 4 and siren = 1 at cycle t+3, zone_latched = 4'b0100. Siren drops after 8 cycles, state_o = 2.
3. Entry grace: ARMED, zone_in[0] rises -> ENTRY. disarm_req 2 cycles later -> DISARMED, siren never 1. Repeat without disarm -> ALARM after 4 ENTRY cycles, zone_latched = 4'b0001.
4. Masking and precedence:
   - zone_mask = 4'b1000 with zone_in = 4'b1000 in ARMED -> stays ARMED.
   - disarm_req in the same cycle as counter expiry in ALARM -> DISARMED, not ARMED.
5. Reset mid-alarm: assert rst asynchronously (mid-cycle) during ALARM -> siren = 0, state_o = 0, zone_latched = 0 immediately, without waiting for a clock edge.
6. ALARM_TAMPER_EN build: tamper_in pulse in DISARMED -> state_o = 4 three cycles later, tamper_latched = 1. tamper_in together with disarm_req -> DISARMED.
